bg_color_sequencer: RTL and testbench

Frame-synchronous controller that drives the 4-bit `bgcolor` select of the background palette block. It steps the palette index through the ambient range 0..MAX_INDEX at a fixed number of frames per step. On request it overrides the index with a timed full-screen flash, then restores the saved index. It sits between game-state logic and the palette, in the `Clk` domain, and is timed by the VGA vertical-sync-derived `frame_clk`.

---
 rtl/bg_color_sequencer_if.sv | 21 ++
 rtl/bg_color_sequencer.sv | 174 +++++++++++++++++
 tb/tb_bg_color_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/bg_color_sequencer_if.sv
// rtl/bg_color_sequencer_if.sv - control and palette-select signals of the background colour sequencer
interface bg_color_sequencer_if;
    logic       frame_clk;
    logic       run;
    logic       set_load;
    logic [3:0] set_index;
    logic       flash_req;
    logic [3:0] bgcolor;
    logic       flash_busy;
    logic       frame_tick;

    modport master (
        output frame_clk, run, set_load, set_index, flash_req,
        input  bgcolor, flash_busy, frame_tick
    );

    modport slave (
        input  frame_clk, run, set_load, set_index, flash_req,
        output bgcolor, flash_busy, frame_tick
    );
endinterface

// File: rtl/bg_color_sequencer.sv
// rtl/bg_color_sequencer.sv - frame-timed background palette index sequencer with flash override
// Optional macro BG_PINGPONG_EN: ping-pong stepping instead of wrap-around.
module bg_color_sequencer #(
    parameter int FRAMES_PER_STEP = 8,
    parameter int FLASH_FRAMES    = 4,
    parameter int MAX_INDEX       = 7,
    parameter int FLASH_INDEX     = 8
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    bg_color_sequencer_if.slave   bus
);

    localparam logic [3:0] MAX_I      = 4'(MAX_INDEX);
    localparam logic [3:0] FLASH_I    = 4'(FLASH_INDEX);
    localparam logic [7:0] STEP_LAST  = 8'(FRAMES_PER_STEP - 1);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_CYCLE = 2'd1,
        S_FLASH = 2'd2
    } state_t;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    logic fc_s1;
    logic fc_s2;
    logic fc_hist;
    logic tick_q;

    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            fc_s1   <= 1'b0;
            fc_s2   <= 1'b0;
            fc_hist <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            fc_s1   <= bus.frame_clk;
            fc_s2   <= fc_s1;
            fc_hist <= fc_s2;
            tick_q  <= fc_s2 & ~fc_hist;
        end
    end

    state_t     state;
    logic [3:0] index;
    logic [3:0] bgcolor_q;
    logic       busy_q;
    logic [7:0] step_cnt;
    logic [7:0] flash_cnt;
    logic [3:0] load_val;
    logic [3:0] step_val;
    logic       step_en;

    always_comb begin
        load_val = (bus.set_index > MAX_I) ? MAX_I : bus.set_index;
    end

    always_comb begin
        step_en = (state == S_CYCLE) && !bus.flash_req && !bus.set_load &&
                  bus.run && tick_q && (step_cnt == STEP_LAST);
    end

`ifdef BG_PINGPONG_EN
    logic dir_up;
    logic step_dir_up;

    // Endpoints force the direction so a load onto an end steps away from it.
    always_comb begin
        step_dir_up = dir_up;
        if (index == MAX_I) begin
            step_dir_up = 1'b0;
        end else if (index == 4'd0) begin
            step_dir_up = 1'b1;
        end
        if (MAX_I == 4'd0) begin
            step_val = 4'd0;
        end else if (step_dir_up) begin
            step_val = index + 4'd1;
        end else begin
            step_val = index - 4'd1;
        end
    end

    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            dir_up <= 1'b1;
        end else if (step_en) begin
            dir_up <= step_dir_up;
        end
    end
`else
    always_comb begin
        step_val = (index == MAX_I) ? 4'd0 : index + 4'd1;
    end
`endif

    // index is left untouched during FLASH, so it doubles as the saved index.
    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state     <= S_HOLD;
            index     <= 4'd0;
            bgcolor_q <= 4'd0;
            busy_q    <= 1'b0;
            step_cnt  <= 8'd0;
            flash_cnt <= 8'd0;
        end else if (bus.flash_req) begin
            state     <= S_FLASH;
            flash_cnt <= 8'd0;
            bgcolor_q <= FLASH_I;
            busy_q    <= 1'b1;
        end else if (bus.set_load) begin
            index    <= load_val;
            step_cnt <= 8'd0;
            if (state != S_FLASH) begin
                bgcolor_q <= load_val;
            end
        end else begin
            case (state)
                S_HOLD: begin
                    if (bus.run) begin
                        state    <= S_CYCLE;
                        step_cnt <= 8'd0;
                    end
                end
                S_CYCLE: begin
                    if (!bus.run) begin
                        state <= S_HOLD;
                    end else if (step_en) begin
                        index     <= step_val;
                        bgcolor_q <= step_val;
                        step_cnt  <= 8'd0;
                    end else if (tick_q) begin
                        step_cnt <= step_cnt + 8'd1;
                    end
                end
                S_FLASH: begin
                    if (tick_q) begin
                        if (flash_cnt == FLASH_LAST) begin
                            state     <= bus.run ? S_CYCLE : S_HOLD;
                            step_cnt  <= 8'd0;
                            flash_cnt <= 8'd0;
                            bgcolor_q <= index;
                            busy_q    <= 1'b0;
                        end else begin
                            flash_cnt <= flash_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= S_HOLD;
                end
            endcase
        end
    end

    assign bus.bgcolor    = bgcolor_q;
    assign bus.flash_busy = busy_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_bg_color_sequencer.sv
// tb/tb_bg_color_sequencer.sv - directed self-checking bench for bg_color_sequencer
module tb_bg_color_sequencer;

`ifdef BG_PINGPONG_EN
    localparam logic [3:0] SEQ [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd6, 4'd5, 4'd4};
    localparam logic [3:0] STEP_A = 4'd2;
    localparam logic [3:0] STEP_B = 4'd1;
    localparam logic [3:0] STEP_C = 4'd0;
`else
    localparam logic [3:0] SEQ [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd1, 4'd2};
    localparam logic [3:0] STEP_A = 4'd4;
    localparam logic [3:0] STEP_B = 4'd3;
    localparam logic [3:0] STEP_C = 4'd4;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    bg_color_sequencer_if bus ();

    bg_color_sequencer #(
        .FRAMES_PER_STEP (2),
        .FLASH_FRAMES    (4),
        .MAX_INDEX       (7),
        .FLASH_INDEX     (8)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame_clk period; frame_tick is high after the third edge, inputs ride on that cycle.
    task automatic frame(input logic fr, input logic ld, input logic [3:0] idx);
        bus.frame_clk = 1'b1;
        repeat (3) cyc();
        bus.flash_req = fr;
        bus.set_load  = ld;
        bus.set_index = idx;
        cyc();
        bus.flash_req = 1'b0;
        bus.set_load  = 1'b0;
        bus.frame_clk = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic flash_exit(input string tag, input logic [3:0] exp);
        bus.frame_clk = 1'b1;
        repeat (3) cyc();
        chk({tag, "_tick"}, {3'b0, bus.frame_tick}, 4'd1);
        chk({tag, "_last_flash"}, bus.bgcolor, 4'd8);
        cyc();
        chk({tag, "_restored"}, bus.bgcolor, exp);
        chk({tag, "_busy_low"}, {3'b0, bus.flash_busy}, 4'd0);
        bus.frame_clk = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.frame_clk = 1'b0;
        bus.run       = 1'b0;
        bus.set_load  = 1'b0;
        bus.set_index = 4'd0;
        bus.flash_req = 1'b0;
        repeat (3) cyc();
        chk("reset_bg", bus.bgcolor, 4'd0);
        chk("reset_busy", {3'b0, bus.flash_busy}, 4'd0);
        chk("reset_tick", {3'b0, bus.frame_tick}, 4'd0);
        rst_n = 1'b1;
        repeat (3) cyc();

        // Auto-cycle over 20 frames.
        bus.run = 1'b1;
        cyc();
        for (int k = 1; k <= 20; k++) begin
            frame(1'b0, 1'b0, 4'd0);
            if (k == 1) chk("cycle_first_hold", bus.bgcolor, 4'd0);
            if (k % 2 == 0) chk($sformatf("cycle_step_%0d", k / 2), bus.bgcolor, SEQ[k / 2 - 1]);
        end

        // Tick timing in HOLD.
        bus.run = 1'b0;
        cyc();
        bus.frame_clk = 1'b1;
        cyc(); chk("tick_c1", {3'b0, bus.frame_tick}, 4'd0);
        cyc(); chk("tick_c2", {3'b0, bus.frame_tick}, 4'd0);
        cyc(); chk("tick_c3", {3'b0, bus.frame_tick}, 4'd1);
        cyc(); chk("tick_c4", {3'b0, bus.frame_tick}, 4'd0);
        bus.frame_clk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("tick_fall_%0d", i), {3'b0, bus.frame_tick}, 4'd0);
        end
        chk("hold_frozen", bus.bgcolor, SEQ[9]);

        // Load then flash with timed restore.
        bus.set_load  = 1'b1;
        bus.set_index = 4'd3;
        cyc();
        bus.set_load  = 1'b0;
        chk("load_3", bus.bgcolor, 4'd3);
        bus.run = 1'b1;
        cyc();
        bus.flash_req = 1'b1;
        cyc();
        bus.flash_req = 1'b0;
        chk("flash_bg", bus.bgcolor, 4'd8);
        chk("flash_busy", {3'b0, bus.flash_busy}, 4'd1);
        repeat (3) frame(1'b0, 1'b0, 4'd0);
        chk("flash_3ticks", bus.bgcolor, 4'd8);
        flash_exit("flash1", 4'd3);
        frame(1'b0, 1'b0, 4'd0);
        chk("post_flash_no_step", bus.bgcolor, 4'd3);
        frame(1'b0, 1'b0, 4'd0);
        chk("post_flash_step", bus.bgcolor, STEP_A);

        // Retrigger on third tick, set_load mid-flash.
        bus.flash_req = 1'b1;
        cyc();
        bus.flash_req = 1'b0;
        repeat (2) frame(1'b0, 1'b0, 4'd0);
        frame(1'b1, 1'b0, 4'd0);
        chk("retrig_bg", bus.bgcolor, 4'd8);
        frame(1'b0, 1'b0, 4'd0);
        chk("retrig_extended", bus.bgcolor, 4'd8);
        bus.set_load  = 1'b1;
        bus.set_index = 4'd5;
        cyc();
        bus.set_load  = 1'b0;
        chk("load_in_flash", bus.bgcolor, 4'd8);
        repeat (2) frame(1'b0, 1'b0, 4'd0);
        chk("retrig_busy", {3'b0, bus.flash_busy}, 4'd1);
        flash_exit("flash2", 4'd5);

        // Clamp and load coincident with a step tick.
        bus.set_load  = 1'b1;
        bus.set_index = 4'd12;
        cyc();
        bus.set_load  = 1'b0;
        chk("clamp", bus.bgcolor, 4'd7);
        frame(1'b0, 1'b0, 4'd0);
        chk("clamp_hold", bus.bgcolor, 4'd7);
        frame(1'b0, 1'b1, 4'd2);
        chk("load_at_tick", bus.bgcolor, 4'd2);
        frame(1'b0, 1'b0, 4'd0);
        chk("load_cnt_cleared", bus.bgcolor, 4'd2);
        frame(1'b0, 1'b0, 4'd0);
        chk("load_then_step", bus.bgcolor, STEP_B);

        // run falling on a step tick.
        frame(1'b0, 1'b0, 4'd0);
        bus.frame_clk = 1'b1;
        repeat (3) cyc();
        bus.run = 1'b0;
        cyc();
        bus.frame_clk = 1'b0;
        repeat (3) cyc();
        chk("run_fall_no_step", bus.bgcolor, STEP_B);
        repeat (2) frame(1'b0, 1'b0, 4'd0);
        chk("hold_no_step", bus.bgcolor, STEP_B);
        bus.run = 1'b1;
        cyc();
        frame(1'b0, 1'b0, 4'd0);
        chk("rerun_cnt_cleared", bus.bgcolor, STEP_B);
        frame(1'b0, 1'b0, 4'd0);
        chk("rerun_step", bus.bgcolor, STEP_C);

        // Reset mid-flash.
        bus.flash_req = 1'b1;
        cyc();
        bus.flash_req = 1'b0;
        chk("pre_reset_flash", bus.bgcolor, 4'd8);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_bg", bus.bgcolor, 4'd0);
        chk("reset_mid_busy", {3'b0, bus.flash_busy}, 4'd0);
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        frame(1'b0, 1'b0, 4'd0);
        chk("post_reset_no_step", bus.bgcolor, 4'd0);
        frame(1'b0, 1'b0, 4'd0);
        chk("post_reset_step", bus.bgcolor, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
